// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_controller
// Description : Converts a 14-bit unsigned value to four BCD digits with a
//               sequential double-dabble engine (one bit per cycle, MSB
//               first), then strobes each digit into its seven-segment
//               decoder with a one-hot write pulse, units first.
//               Optional feature macro: DISPLAY_SATURATE_EN
//                 defined   -> values above 9999 are shown as 9999
//                 undefined -> values above 9999 are shown modulo 10000
//               In both builds overflow flags values above 9999.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] value,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [15:0] digitOut,
   output logic [3:0]  displayWrite
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   localparam logic [13:0] c_max_value = 14'd9999;
   // Step counter value on the fourteenth (final) conversion edge
   localparam logic [3:0]  c_last_step = 4'd13;

   state_t      r_state;
   logic [13:0] r_bin;       // binary operand, shifted out MSB first
   logic [19:0] r_acc;       // five-digit BCD accumulator
   logic [3:0]  r_cnt;       // conversion steps already performed
   logic        r_ovf_cap;   // overflow of the captured value

   logic        w_value_ovf;
   logic [13:0] w_value_cap;
   logic [19:0] w_acc_adj;
   logic [19:0] w_acc_next;

   assign w_value_ovf = (value > c_max_value);

`ifdef DISPLAY_SATURATE_EN
   // Clamp oversized values so the display shows 9999
   assign w_value_cap = w_value_ovf ? c_max_value : value;
`else
   // Full value is converted; the ten-thousands digit is simply not shown
   assign w_value_cap = value;
`endif

   // Add-3 correction on every BCD digit that is 5 or more before shifting
   genvar i;
   generate
      for (i = 0; i < 5; i++) begin : g_digit
         assign w_acc_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ?
                                      (r_acc[4*i +: 4] + 4'd3) : r_acc[4*i +: 4];
      end
   endgenerate

   // Shift the corrected accumulator left, pulling in the next binary MSB
   assign w_acc_next = (w_acc_adj << 1) | {19'd0, r_bin[13]};

   // Control FSM: capture, 14 conversion steps, four digit strobes, done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_bin        <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_ovf_cap    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         digitOut     <= '0;
         displayWrite <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bin     <= w_value_cap;
                  r_ovf_cap <= w_value_ovf;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  busy      <= 1'b1;
                  r_state   <= CONVERT;
               end
            end
            CONVERT: begin
               r_acc <= w_acc_next;
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt + 4'd1;
               // Overflow is published on the first conversion edge
               if (r_cnt == 4'd0) begin
                  overflow <= r_ovf_cap;
               end
               if (r_cnt == c_last_step) begin
                  digitOut     <= w_acc_next[15:0];
                  displayWrite <= 4'b0001;
                  r_state      <= WRITE;
               end
            end
            WRITE: begin
               if (displayWrite[3]) begin
                  displayWrite <= 4'b0000;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  displayWrite <= displayWrite << 1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_controller
// Description : Scoreboard bench for display_scan_controller. Stimulus pushes
//               one expected transaction per accepted start; a negedge
//               monitor checks busy/strobe/done timing, digits and overflow
//               against a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [13:0] value = '0;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] digitOut;
   logic [3:0]  displayWrite;

   always #5 clk = ~clk;

   display_scan_controller dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .value        (value),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .digitOut     (digitOut),
      .displayWrite (displayWrite)
   );

   typedef struct {
      int          e0;
      logic [15:0] dig;
      logic        ovf;
   } txn_t;

   txn_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   // Rising-edge counter; after edge N the monitor sees cyc == N
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: what the four-digit display should show for value v
   function automatic logic [15:0] ref_digits(input int v);
      int          shown;
      logic [15:0] r;
`ifdef DISPLAY_SATURATE_EN
      shown = (v > 9999) ? 9999 : v;
`else
      shown = v % 10000;
`endif
      r[15:12] = 4'(shown / 1000);
      r[11:8]  = 4'((shown / 100) % 10);
      r[7:4]   = 4'((shown / 10) % 10);
      r[3:0]   = 4'(shown % 10);
      return r;
   endfunction

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [13:0] v, output int e0);
      txn_t t;
      @(negedge clk);
      start = 1'b1;
      value = v;
      @(posedge clk);
      #1;
      e0    = cyc;
      start = 1'b0;
      t.e0  = e0;
      t.dig = ref_digits(int'(v));
      t.ovf = (v > 14'd9999);
      sb.push_back(t);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},     32'(busy),         32'd0);
      chk({tag, "_done"},     32'(done),         32'd0);
      chk({tag, "_overflow"}, 32'(overflow),     32'd0);
      chk({tag, "_strobe"},   32'(displayWrite), 32'd0);
      chk({tag, "_digits"},   32'(digitOut),     32'd0);
   endtask

   // Monitor: timing and data check against the oldest pending transaction
   always @(negedge clk) begin
      int k;
      if (reset) begin
         if (displayWrite != 4'b0000) begin
            chk("strobe_onehot", 32'($onehot(displayWrite)), 32'd1);
            for (int d = 0; d < 4; d++)
               chk("nibble_range", 32'(digitOut[4*d +: 4] <= 4'd9), 32'd1);
         end
         if (sb.size() == 0 || cyc < sb[0].e0) begin
            chk("idle_busy",   32'(busy),         32'd0);
            chk("idle_strobe", 32'(displayWrite), 32'd0);
            chk("idle_done",   32'(done),         32'd0);
         end else begin
            k = cyc - sb[0].e0;
            chk("busy",   32'(busy), 32'(k < 18));
            chk("strobe", 32'(displayWrite),
                32'((k >= 14 && k <= 17) ? (4'b0001 << (k - 14)) : 4'b0000));
            chk("done",   32'(done), 32'(k == 18));
            if (k >= 1)  chk("overflow", 32'(overflow), 32'(sb[0].ovf));
            if (k >= 14) chk("digits",   32'(digitOut), 32'(sb[0].dig));
            if (k >= 18) void'(sb.pop_front());
         end
      end
   end

   initial begin
      int e0;
      int e0_prev;
      int gap;
      int r;
      logic [13:0] v;

      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      check_zero("por");
      @(posedge clk);
      #3 reset = 1'b1;

      // Basic conversion
      issue(14'd1234, e0);
      wait_cyc(e0 + 18);

      // Back-to-back: 9999 then 0, second start at E0+19
      issue(14'd9999, e0_prev);
      wait_cyc(e0_prev + 18);
      issue(14'd0, e0);
      chk("b2b_spacing", 32'(e0 - e0_prev), 32'd19);
      wait_cyc(e0 + 18);

      // Overflowing value
      issue(14'd12345, e0);
      wait_cyc(e0 + 18);

      // Starts during a busy sequence must be ignored
      issue(14'd42, e0);
      wait_cyc(e0 + 4);
      @(negedge clk); start = 1'b1; value = 14'd1111;
      @(posedge clk); #1 start = 1'b0;
      wait_cyc(e0 + 15);
      @(negedge clk); start = 1'b1; value = 14'd2222;
      @(posedge clk); #1 start = 1'b0;
      wait_cyc(e0 + 18);
      repeat (3) @(posedge clk);

      // Asynchronous reset mid-CONVERT
      issue(14'd12345, e0);
      wait_cyc(e0 + 7);
      #1 reset = 1'b0;
      sb.delete();
      #1 check_zero("rst_conv");
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      issue(14'd7, e0);
      wait_cyc(e0 + 18);

      // Asynchronous reset mid-WRITE
      issue(14'd16383, e0);
      wait_cyc(e0 + 16);
      #1 reset = 1'b0;
      sb.delete();
      #1 check_zero("rst_write");
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      issue(14'd7, e0);
      wait_cyc(e0 + 18);

      // Randomized traffic with occasional back-to-back starts
      for (int n = 0; n < 20; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       v = 14'd9999;
            1:       v = 14'd10000;
            2:       v = 14'd0;
            default: v = 14'($urandom_range(0, 16383));
         endcase
         gap = $urandom_range(0, 2);
         repeat (gap) @(posedge clk);
         issue(v, e0);
         wait_cyc(e0 + 18);
      end

      // Drain with a bounded wait
      for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
